// File: rtl/atm_pkg.sv
// Shared constants, state encoding and the bytewise HEC CRC step for the ATM cell path.
package atm_pkg;

  localparam int         ATM_CELL_BYTES = 53;
  localparam int         ATM_HDR_BYTES  = 5;
  localparam logic [7:0] HEC_POLY       = 8'h07;
  localparam logic [7:0] HEC_COSET      = 8'h55;

  typedef enum logic {
    ST_HUNT     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } asm_state_t;

  // One CRC-8 step over a full byte, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ HEC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/atm_hec_crc8.sv
// Running CRC-8 over a byte stream; clear and enable together restart from
// zero with the current byte folded in, so a new cell needs no idle cycle.
module atm_hec_crc8
  import atm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_en,
  input  logic       i_clr,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;

  // CRC accumulator: restart on clear, fold in a byte when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_crc <= 8'h00;
    end else if (i_en) begin
      r_crc <= crc8_byte(i_clr ? 8'h00 : r_crc, i_data);
    end else if (i_clr) begin
      r_crc <= 8'h00;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/atm_cell_assembler.sv
// Byte-serial ATM cell assembler with sop delineation, header HEC check,
// a single-cell output register with ready/valid, and saturating statistics.
//
// state       | meaning
// ST_HUNT     | waiting for an sop byte; non-sop bytes are discarded
// ST_ASSEMBLE | collecting bytes 1..CELL_BYTES-1 of the current cell
module atm_cell_assembler
  import atm_pkg::*;
#(
  parameter int CELL_BYTES = ATM_CELL_BYTES,
  parameter int HDR_BYTES  = ATM_HDR_BYTES,
  parameter int DROP_BAD   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  output logic                    in_ready,
  output logic [CELL_BYTES*8-1:0] cell_data,
  output logic                    cell_valid,
  output logic                    cell_hec_err,
  input  logic                    cell_ready,
  output logic                    sync_err,
  output logic [CNT_W-1:0]        cnt_ok,
  output logic [CNT_W-1:0]        cnt_hec,
  output logic [CNT_W-1:0]        cnt_sync
);

  localparam int            CW       = $clog2(CELL_BYTES);
  localparam logic [CW-1:0] LAST_IDX = CW'(CELL_BYTES - 1);
  localparam logic [CW-1:0] HEC_IDX  = CW'(HDR_BYTES - 1);

  asm_state_t              r_state, w_state_nxt;
  logic [CW-1:0]           r_byte_cnt, w_cnt_nxt, w_idx;
  logic [CELL_BYTES*8-1:0] r_buf;
  logic                    r_hec_bad;
  logic [7:0]              w_crc;
  logic                    w_in_ready, w_acc, w_start, w_abort, w_take, w_complete, w_load;

  // State register: FSM state and byte index of the next byte to store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_cnt_nxt;
    end
  end

  // Next state: sop always restarts at count 1; the last byte returns to hunt.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_byte_cnt;
    if (w_start) begin
      w_state_nxt = ST_ASSEMBLE;
      w_cnt_nxt   = CW'(1);
    end else if (w_complete) begin
      w_state_nxt = ST_HUNT;
      w_cnt_nxt   = '0;
    end else if (w_acc && r_state == ST_ASSEMBLE) begin
      w_cnt_nxt   = r_byte_cnt + 1'b1;
    end
  end

  // FSM outputs: only the final byte can stall, and only when the held cell cannot leave now.
  always_comb begin
    w_in_ready = !(r_state == ST_ASSEMBLE && r_byte_cnt == LAST_IDX && cell_valid && !cell_ready);
    w_acc      = in_valid && w_in_ready;
    w_start    = w_acc && in_sop;
    w_abort    = w_start && r_state == ST_ASSEMBLE;
    w_take     = w_start || (w_acc && r_state == ST_ASSEMBLE);
    w_idx      = w_start ? '0 : r_byte_cnt;
    w_complete = w_acc && !in_sop && r_state == ST_ASSEMBLE && r_byte_cnt == LAST_IDX;
    w_load     = w_complete && (!r_hec_bad || DROP_BAD == 0);
  end

  assign in_ready = w_in_ready;

  atm_hec_crc8 u_hec (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (in_data),
    .i_en   (w_take && w_idx < HEC_IDX),
    .i_clr  (w_start),
    .o_crc  (w_crc)
  );

  // Cell buffer: byte 0 lands in the MSBs; stale bytes of an aborted cell get overwritten.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CELL_BYTES; i++) begin
      if (w_take && w_idx == CW'(i)) begin
        r_buf[(CELL_BYTES-1-i)*8 +: 8] <= in_data;
      end
    end
  end

  // HEC verdict latched as the HEC byte itself arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hec_bad <= 1'b0;
    end else if (w_take && w_idx == HEC_IDX) begin
      r_hec_bad <= (in_data != (w_crc ^ HEC_COSET));
    end
  end

  // Output register: loads straight from the buffer plus the final byte, so load and drain can coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cell_valid   <= 1'b0;
      cell_hec_err <= 1'b0;
      cell_data    <= '0;
    end else if (w_load) begin
      cell_valid   <= 1'b1;
      cell_hec_err <= r_hec_bad;
      cell_data    <= {r_buf[CELL_BYTES*8-1:8], in_data};
    end else if (cell_valid && cell_ready) begin
      cell_valid   <= 1'b0;
    end
  end

  // Abort pulse and saturating statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
      cnt_ok   <= '0;
      cnt_hec  <= '0;
      cnt_sync <= '0;
    end else begin
      sync_err <= w_abort;
      if (w_complete && !r_hec_bad && cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
      if (w_complete && r_hec_bad && cnt_hec != '1) cnt_hec <= cnt_hec + 1'b1;
      if (w_abort && cnt_sync != '1) cnt_sync <= cnt_sync + 1'b1;
    end
  end

endmodule
